// File: rtl/nlfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nlfsr_pkg
// Purpose  : Shared types and constants for the 16-bit NLFSR core.
// Revision : 1.0 - initial release
// ============================================================================
package nlfsr_pkg;

    localparam int NLFSR_WIDTH = 16;
    localparam logic [NLFSR_WIDTH-1:0] NLFSR_ZERO_SEED_SUB = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } nlfsr_state_e;

    // An all-zero seed would park the register at a fixed point of the feedback.
    function automatic logic [NLFSR_WIDTH-1:0] seed_fixup(input logic [NLFSR_WIDTH-1:0] s);
        return (s == '0) ? NLFSR_ZERO_SEED_SUB : s;
    endfunction

endpackage : nlfsr_pkg
`default_nettype wire

// File: rtl/nlfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : nlfsr_core
// Purpose  : 16-bit NLFSR state machine: seed load, warm-up discard, then one
//            keystream bit per handshake. Optional lock-up detection is
//            enabled by defining NLFSR_LOCKUP_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nlfsr_core
    import nlfsr_pkg::*;
#(
    parameter int WARMUP = 32
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   seed_valid,
    input  logic [NLFSR_WIDTH-1:0] seed,
    output logic                   seed_ready,
    input  logic                   fb,
    output logic [NLFSR_WIDTH-1:0] register,
    output logic                   out_valid,
    output logic                   out_bit,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   lock_up
);

    localparam int c_CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WARM_LAST = WARMUP[c_CNT_W-1:0];

    nlfsr_state_e           r_state;
    logic                   r_phase;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [NLFSR_WIDTH-1:0] r_reg;
    logic                   r_out_valid;
    logic                   r_out_bit;
    logic                   r_lock_up;

    logic                   w_seed_ready;
    logic                   w_accept;
    logic                   w_shift_ok;
    logic                   w_shift;
    logic                   w_lock;
    logic [NLFSR_WIDTH-1:0] w_next_reg;
    logic [c_CNT_W-1:0]     w_cnt_inc;

    assign w_seed_ready = !res && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept     = seed_valid && w_seed_ready;
    assign w_shift_ok   = (r_state == ST_WARM) ||
                          ((r_state == ST_RUN) && (!r_out_valid || out_ready));
    // A simultaneous seed accept takes priority and suppresses the shift.
    assign w_shift      = r_phase && w_shift_ok && !w_accept;
    assign w_next_reg   = {r_reg[NLFSR_WIDTH-2:0], fb};
    assign w_cnt_inc    = r_cnt + 1'b1;

`ifdef NLFSR_LOCKUP_DET_EN
    assign w_lock = (r_state == ST_RUN) && (w_next_reg == '0);
`else
    assign w_lock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            r_reg       <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_lock_up   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_reg       <= seed_fixup(seed);
                r_phase     <= 1'b0;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                r_lock_up   <= 1'b0;
                r_state     <= (WARMUP == 0) ? ST_RUN : ST_WARM;
            end else begin
                // Phase parks at 1 while stalled so the registered taps stay valid.
                if ((r_state != ST_IDLE) && !(r_phase && !w_shift_ok)) begin
                    r_phase <= ~r_phase;
                end
                if (w_shift) begin
                    r_reg <= w_next_reg;
                    if (r_state == ST_WARM) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_WARM_LAST) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_out_bit   <= r_reg[NLFSR_WIDTH-1];
                        r_out_valid <= 1'b1;
                        if (w_lock) begin
                            r_lock_up <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
            end
        end
    end

    assign seed_ready = w_seed_ready;
    assign register   = r_reg;
    assign out_valid  = r_out_valid;
    assign out_bit    = r_out_bit;
    assign busy       = (r_state != ST_IDLE);
    assign lock_up    = r_lock_up;

endmodule : nlfsr_core
`default_nettype wire

// File: tb/tb_nlfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_nlfsr_core
// Purpose  : Scoreboard bench for nlfsr_core (WARMUP=0 and WARMUP=4 instances)
//            with a registered nonlinear feedback-stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nlfsr_core;

    logic        clk = 1'b0;
    logic        res;
    logic        sv0, sv4;
    logic [15:0] seed;
    logic        out_ready;
    logic        fb_mode;
    logic        fb0, fb4;
    logic        sr0, sr4, ov0, ov4, ob0, ob4, busy0, busy4, lk0, lk4;
    logic [15:0] reg0, reg4;

    int errors = 0;
    int checks = 0;

    logic        exp_bit_q[$];
    logic [15:0] exp_reg_q[$];

    always #5 clk = ~clk;

    function automatic logic fbf(input logic [15:0] r);
        return r[15] ^ r[13] ^ r[11] ^ (r[9] & r[6]) ^ r[2];
    endfunction

    // Feedback stage model: taps registered, so fb lags register by one cycle.
    always @(posedge clk) begin
        fb0 <= fb_mode ? fbf(reg0) : 1'b0;
        fb4 <= fb_mode ? fbf(reg4) : 1'b0;
    end

    nlfsr_core #(.WARMUP(0)) dut0 (
        .clk(clk), .res(res), .seed_valid(sv0), .seed(seed), .seed_ready(sr0),
        .fb(fb0), .register(reg0), .out_valid(ov0), .out_bit(ob0),
        .out_ready(out_ready), .busy(busy0), .lock_up(lk0)
    );

    nlfsr_core #(.WARMUP(4)) dut4 (
        .clk(clk), .res(res), .seed_valid(sv4), .seed(seed), .seed_ready(sr4),
        .fb(fb4), .register(reg4), .out_valid(ov4), .out_bit(ob4),
        .out_ready(out_ready), .busy(busy4), .lock_up(lk4)
    );

    // Push the expected keystream (after skipping warm-up shifts) and the
    // register value that accompanies each emitted bit.
    task automatic gen(input logic [15:0] s, input int skip, input int n);
        logic [15:0] r;
        logic        b;
        r = (s == 16'h0000) ? 16'h0001 : s;
        for (int k = 1; k <= skip + n; k++) begin
            b = r[15];
            r = {r[14:0], fb_mode ? fbf(r) : 1'b0};
            if (k > skip) begin
                exp_bit_q.push_back(b);
                exp_reg_q.push_back(r);
            end
        end
    endtask

    task automatic test_reset;
        res = 1'b1; sv0 = 1'b0; sv4 = 1'b0; seed = 16'h0000;
        out_ready = 1'b1; fb_mode = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (sr0 !== 1'b0) begin errors++; $display("FAIL reset_seed_ready_in_res: got %b want 0", sr0); end
        res = 1'b0; #1;
        checks++; if (reg0 !== 16'h0000) begin errors++; $display("FAIL reset_register: got %h want 0000", reg0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        checks++; if (ob0 !== 1'b0) begin errors++; $display("FAIL reset_out_bit: got %b want 0", ob0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (sr0 !== 1'b1) begin errors++; $display("FAIL reset_seed_ready: got %b want 1", sr0); end
        checks++; if (lk0 !== 1'b0) begin errors++; $display("FAIL reset_lock_up: got %b want 0", lk0); end
    endtask

    task automatic test_zero_seed;
        seed = 16'h0000; sv0 = 1'b1; sv4 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0; sv4 = 1'b0;
        checks++; if (reg0 !== 16'h0001) begin errors++; $display("FAIL zero_seed_reg0: got %h want 0001", reg0); end
        checks++; if (reg4 !== 16'h0001) begin errors++; $display("FAIL zero_seed_reg4: got %h want 0001", reg4); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL zero_seed_busy: got %b want 1", busy0); end
        checks++; if (sr0 !== 1'b1) begin errors++; $display("FAIL zero_seed_ready_run: got %b want 1", sr0); end
        checks++; if (sr4 !== 1'b0) begin errors++; $display("FAIL zero_seed_ready_warm: got %b want 0", sr4); end
    endtask

    task automatic test_known_shift;
        int got, cyc, first, last;
        logic eb;
        logic [15:0] er;
        fb_mode = 1'b0; out_ready = 1'b1;
        seed = 16'h8001; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        checks++; if (reg0 !== 16'h8001) begin errors++; $display("FAIL known_seed_reg: got %h want 8001", reg0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL known_seed_valid: got %b want 0", ov0); end
        exp_bit_q.delete(); exp_reg_q.delete();
        gen(16'h8001, 0, 16);
        got = 0; cyc = 1; first = -1; last = -1;
        while (got < 16 && cyc < 80) begin
            @(negedge clk); cyc++;
            if (ov0 && out_ready) begin
                if (first < 0) first = cyc;
                if (last >= 0) begin
                    checks++; if (cyc - last != 2) begin errors++; $display("FAIL known_bit_spacing: got %0d want 2", cyc - last); end
                end
                if (got == 0) begin
                    checks++; if (reg0 !== 16'h0002) begin errors++; $display("FAIL known_reg_after_1: got %h want 0002", reg0); end
                end
                last = cyc;
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob0 !== eb) begin errors++; $display("FAIL known_bit%0d: got %b want %b", got, ob0, eb); end
                checks++; if (reg0 !== er) begin errors++; $display("FAIL known_reg%0d: got %h want %h", got, reg0, er); end
                got++;
            end
        end
        checks++; if (got != 16) begin errors++; $display("FAIL known_timeout: got %0d bits want 16", got); end
        checks++; if (first != 3) begin errors++; $display("FAIL known_first_valid: got T+%0d want T+3", first); end
    endtask

    task automatic test_lockup;
`ifdef NLFSR_LOCKUP_DET_EN
        checks++; if (lk0 !== 1'b1) begin errors++; $display("FAIL lockup_flag: got %b want 1", lk0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL lockup_busy: got %b want 0", busy0); end
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL lockup_valid_after: got %b want 0", ov0); end
        checks++; if (lk0 !== 1'b1) begin errors++; $display("FAIL lockup_sticky: got %b want 1", lk0); end
        checks++; if (reg0 !== 16'h0000) begin errors++; $display("FAIL lockup_reg: got %h want 0000", reg0); end
`else
        int got, cyc;
        logic eb;
        logic [15:0] er;
        checks++; if (lk0 !== 1'b0) begin errors++; $display("FAIL lockup_flag: got %b want 0", lk0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL lockup_busy: got %b want 1", busy0); end
        repeat (2) begin
            exp_bit_q.push_back(1'b0);
            exp_reg_q.push_back(16'h0000);
        end
        got = 0; cyc = 0;
        while (got < 2 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (ov0 && out_ready) begin
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob0 !== eb) begin errors++; $display("FAIL lockup_zero_bit: got %b want %b", ob0, eb); end
                checks++; if (reg0 !== er) begin errors++; $display("FAIL lockup_zero_reg: got %h want %h", reg0, er); end
                checks++; if (lk0 !== 1'b0) begin errors++; $display("FAIL lockup_flag_run: got %b want 0", lk0); end
                got++;
            end
        end
        checks++; if (got != 2) begin errors++; $display("FAIL lockup_timeout: got %0d bits want 2", got); end
`endif
    endtask

    task automatic test_backpressure;
        int got, cyc;
        logic eb, held_bit;
        logic [15:0] er, held_reg;
        fb_mode = 1'b1; out_ready = 1'b1;
        seed = 16'hACE1; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        exp_bit_q.delete(); exp_reg_q.delete();
        gen(16'hACE1, 0, 12);
        got = 0; cyc = 0;
        while (got < 3 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ov0 && out_ready) begin
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob0 !== eb) begin errors++; $display("FAIL bp_pre_bit%0d: got %b want %b", got, ob0, eb); end
                checks++; if (reg0 !== er) begin errors++; $display("FAIL bp_pre_reg%0d: got %h want %h", got, reg0, er); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL bp_pre_timeout: got %0d bits want 3", got); end
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!ov0 && cyc < 10);
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_wait_valid: got %b want 1", ov0); end
        out_ready = 1'b0;
        held_bit = ob0; held_reg = reg0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", i, ov0); end
            checks++; if (ob0 !== held_bit) begin errors++; $display("FAIL bp_hold_bit c%0d: got %b want %b", i, ob0, held_bit); end
            checks++; if (reg0 !== held_reg) begin errors++; $display("FAIL bp_hold_reg c%0d: got %h want %h", i, reg0, held_reg); end
        end
        out_ready = 1'b1;
        eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
        checks++; if (ob0 !== eb) begin errors++; $display("FAIL bp_release_bit: got %b want %b", ob0, eb); end
        checks++; if (reg0 !== er) begin errors++; $display("FAIL bp_release_reg: got %h want %h", reg0, er); end
        @(negedge clk);
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL bp_next_shift_valid: got %b want 1", ov0); end
        eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
        checks++; if (ob0 !== eb) begin errors++; $display("FAIL bp_next_bit: got %b want %b", ob0, eb); end
        checks++; if (reg0 !== er) begin errors++; $display("FAIL bp_next_reg: got %h want %h", reg0, er); end
        got = 0; cyc = 0;
        while (got < 7 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ov0 && out_ready) begin
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob0 !== eb) begin errors++; $display("FAIL bp_post_bit%0d: got %b want %b", got, ob0, eb); end
                checks++; if (reg0 !== er) begin errors++; $display("FAIL bp_post_reg%0d: got %h want %h", got, reg0, er); end
                got++;
            end
        end
        checks++; if (got != 7) begin errors++; $display("FAIL bp_post_timeout: got %0d bits want 7", got); end
    endtask

    task automatic test_warmup_reseed;
        int got, cyc, first;
        logic eb;
        logic [15:0] er;
        fb_mode = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (!sr4 && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        seed = 16'hACE1; sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0;
        checks++; if (reg4 !== 16'hACE1) begin errors++; $display("FAIL warm_seed_reg: got %h want ace1", reg4); end
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL warm_seed_valid: got %b want 0", ov4); end
        exp_bit_q.delete(); exp_reg_q.delete();
        gen(16'hACE1, 4, 6);
        got = 0; cyc = 1; first = -1;
        while (got < 6 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (ov4 && out_ready) begin
                if (first < 0) first = cyc;
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob4 !== eb) begin errors++; $display("FAIL warm_bit%0d: got %b want %b", got, ob4, eb); end
                checks++; if (reg4 !== er) begin errors++; $display("FAIL warm_reg%0d: got %h want %h", got, reg4, er); end
                got++;
            end
        end
        checks++; if (got != 6) begin errors++; $display("FAIL warm_timeout: got %0d bits want 6", got); end
        checks++; if (first != 11) begin errors++; $display("FAIL warm_first_valid: got T+%0d want T+11", first); end
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (!ov4 && cyc < 10);
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL reseed_wait_valid: got %b want 1", ov4); end
        out_ready = 1'b0;
        seed = 16'h1234; sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0; out_ready = 1'b1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reseed_drop_valid: got %b want 0", ov4); end
        checks++; if (reg4 !== 16'h1234) begin errors++; $display("FAIL reseed_reg: got %h want 1234", reg4); end
        checks++; if (sr4 !== 1'b0) begin errors++; $display("FAIL reseed_ready_warm: got %b want 0", sr4); end
        exp_bit_q.delete(); exp_reg_q.delete();
        gen(16'h1234, 4, 3);
        got = 0; cyc = 1;
        while (got < 3 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (ov4 && out_ready) begin
                eb = exp_bit_q.pop_front(); er = exp_reg_q.pop_front();
                checks++; if (ob4 !== eb) begin errors++; $display("FAIL reseed_bit%0d: got %b want %b", got, ob4, eb); end
                checks++; if (reg4 !== er) begin errors++; $display("FAIL reseed_reg%0d: got %h want %h", got, reg4, er); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL reseed_timeout: got %0d bits want 3", got); end
    endtask

    task automatic test_reset_mid_run;
        seed = 16'h5A5A; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", busy0); end
        res = 1'b1;
        @(negedge clk);
        res = 1'b0; #1;
        checks++; if (reg0 !== 16'h0000) begin errors++; $display("FAIL midrst_reg: got %h want 0000", reg0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", ov0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        checks++; if (sr0 !== 1'b1) begin errors++; $display("FAIL midrst_seed_ready: got %b want 1", sr0); end
        checks++; if (lk0 !== 1'b0) begin errors++; $display("FAIL midrst_lock_up: got %b want 0", lk0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_seed();
        test_known_shift();
        test_lockup();
        test_backpressure();
        test_warmup_reseed();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nlfsr_core
`default_nettype wire

// File: doc/nlfsr_core.md
# nlfsr_core

Sixteen-bit nonlinear feedback shift register (NLFSR) state machine for the random module. It owns the `register[15:0]` state vector and accepts seeds through a valid/ready handshake. It discards a configurable number of warm-up shifts, then emits one keystream bit per accepted handshake. It sits directly upstream of the tap-selection/feedback stage: it drives that stage's `register` input and consumes its registered feedback bit `result` on `fb`.

## Interface

Parameters:
- `WARMUP`, default 32: number of shifts discarded after each seed load before any output. 0 means output starts immediately.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `res` input 1: reset, synchronous, active-high.
- `seed_valid` input 1: seed offered.
- `seed` input 16: seed value.
- `seed_ready` output 1: seed can be accepted.
- `fb` input 1: feedback bit from the feedback stage; its taps are registered, so it reflects `register` from the previous cycle.
- `register` output 16: NLFSR state, fed to the feedback stage.
- `out_valid` output 1: keystream bit available.
- `out_bit` output 1: keystream bit, the old `register[15]` shifted out.
- `out_ready` input 1: downstream accepts `out_bit`.
- `busy` output 1: state is not IDLE.
- `lock_up` output 1: sticky all-zero lock-up flag (see Configuration).

## Operation

- States: IDLE, WARM, RUN.
- Reset values: state IDLE, `register` 16'h0000, `out_valid` 0, `out_bit` 0, `lock_up` 0, phase 0, warm-up counter 0.
- `seed_ready` = 1 in IDLE and RUN. It is 0 in WARM and while `res` is high.
- Seed accept happens when `seed_valid & seed_ready`:
  - `register` <= `seed`. A seed of 16'h0000 is replaced by 16'h0001.
  - Phase <= 0 and counter <= 0.
  - `out_valid` <= 0, so any pending bit is dropped.
  - State <= WARM, or RUN if `WARMUP` == 0.
- Phase toggles every cycle outside IDLE.
  - Phase 0: the feedback stage samples `register`.
  - Phase 1: `fb` is valid for the current `register`.
- Shift takes place at the end of a phase-1 cycle, when allowed:
  - `register` <= {`register[14:0]`, `fb`}.
  - Shifted-out bit is `register[15]`.
  - Phase returns to 0.
- WARM: shifts unconditionally. Each shift increments the counter; the shifted-out bit is discarded. The shift that brings the counter to `WARMUP` moves the state to RUN.
- RUN: a shift is allowed only if `!out_valid || out_ready`. On a shift, `out_bit` <= old `register[15]` and `out_valid` <= 1.
  - If no shift is allowed, phase stays at 1, `register` holds, and the taps stay valid.
  - An accept without a simultaneous shift clears `out_valid`.
- Seed accept and shift in the same cycle: the seed wins; the shift is dropped.
- `res` during any state returns all registers to reset values on the next edge.

## Timing

- Seed accepted at the edge ending cycle T gives `register` = seed in cycle T+1 (phase 0).
- First shift happens at the edge ending cycle T+2.
- Peak rate is one shift per 2 cycles.
- First `out_valid` appears in cycle T+1+2·(`WARMUP`+1), with `out_ready` held high.
- With `out_ready` held high, `out_valid` alternates 1/0 and carries one bit per 2 cycles.
- `out_valid`/`out_bit` are stable while `out_valid & !out_ready`.
- Outputs are registered, with no combinational path from `out_ready` to `out_valid`. `seed_ready` and `busy` decode directly from state.

## Configuration

- `NLFSR_LOCKUP_DET_EN` defined:
  - In RUN, a shift that produces `register` == 16'h0000 sets `lock_up` (sticky until `res` or seed accept).
  - State <= IDLE next edge. The bit produced by that shift is still presented on `out_bit`/`out_valid`.
- Undefined: `lock_up` is tied 0 and an all-zero state keeps shifting.

## Structure

- Package `nlfsr_pkg` holds:
  - the state enum (IDLE, WARM, RUN);
  - `NLFSR_WIDTH` = 16;
  - `NLFSR_ZERO_SEED_SUB` = 16'h0001.
- No sub-module. The feedback stage is instantiated beside this block by the parent, connecting `register`→`register` and `result`→`fb`.

## Test plan

- **Reset mid-RUN:** assert `res` for 1 cycle during RUN → next cycle `register`=0, `out_valid`=0, `busy`=0, `seed_ready`=1.
- **Zero seed:** `WARMUP`=0, seed 16'h0000 → `register` reads 16'h0001 the cycle after accept.
- **Known shift sequence:** `WARMUP`=0, all taps selecting nothing (`fb`≡0), seed 16'h8001, `out_ready`=1 → `out_bit` sequence 1,0×14,1, one bit per 2 cycles; `register` after 1 shift is 16'h0002.
- **Lock-up detection:** same setup as the known-shift test, with `NLFSR_LOCKUP_DET_EN` defined → after shift 16, `lock_up`=1, state IDLE, `busy`=0. With the macro undefined, bits keep coming as 0 and `lock_up` stays 0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in RUN → `out_valid`=1, `out_bit` and `register` frozen. Release → one accept, then the next shift within 1 cycle.
- **Warm-up and reseed:** `WARMUP`=4, seed 16'hACE1 → first `out_valid` at T+11. Reseeding during RUN with `out_valid`=1 → `out_valid`=0 the next cycle and `register`=new seed.
